// File: rtl/lsu_ctrl.sv
// MEM-stage load/store controller: byte/half/word accesses on a word-addressed memory port,
// sub-word stores done as read-modify-write. Optional macro: LSU_MISALIGN_CHECK_EN.
module lsu_ctrl #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_write,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_resp_valid,
    output logic [31:0]       o_resp_rdata,
    output logic              o_resp_misaligned,
    output logic              o_stall,
    output logic [31:0]       o_mem_adr,
    output logic [31:0]       o_mem_wdata,
    output logic              o_mem_read,
    output logic              o_mem_write,
    input  logic [31:0]       i_mem_rdata
);

    typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StRmwWr, StResp} state_e;

    state_e      r_state;
    logic [1:0]  r_lane;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [31:0] r_wdata;
    logic [31:0] r_wbuf;
    logic [31:0] r_mem_adr;
    logic [31:0] r_resp_rdata;
    logic        r_resp_valid;
    logic        r_resp_misaligned;
    logic        r_mem_read;
    logic        r_mem_write;

    logic [ADDR_W-1:0] w_acc_addr;
    logic              w_misaligned;
    logic [31:0]       w_word_adr;
    logic [31:0]       w_rd_shift;
    logic [31:0]       w_load_data;
    logic [31:0]       w_lane_mask;
    logic [31:0]       w_merged;

    always_comb begin
        w_acc_addr = i_req_addr;
`ifdef LSU_MISALIGN_CHECK_EN
        w_misaligned = ((i_req_size == 2'b01) && i_req_addr[0]) ||
                       (i_req_size[1] && (i_req_addr[1:0] != 2'b00));
`else
        // Without the check, unaligned halves/words silently round down to alignment.
        w_misaligned = 1'b0;
        if (i_req_size == 2'b01) begin
            w_acc_addr[0] = 1'b0;
        end else if (i_req_size[1]) begin
            w_acc_addr[1:0] = 2'b00;
        end
`endif
    end

    always_comb begin
        w_word_adr = '0;
        w_word_adr[ADDR_W-3:0] = w_acc_addr[ADDR_W-1:2];
    end

    assign w_rd_shift = i_mem_rdata >> {r_lane, 3'b000};

    always_comb begin
        case (r_size)
            2'b00: w_load_data = r_unsigned ? {24'h0, w_rd_shift[7:0]}
                                            : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01: w_load_data = r_unsigned ? {16'h0, w_rd_shift[15:0]}
                                            : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_load_data = i_mem_rdata;
        endcase
    end

    assign w_lane_mask = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF)
                         << {r_lane, 3'b000};
    assign w_merged    = (i_mem_rdata & ~w_lane_mask) |
                         ((r_wdata << {r_lane, 3'b000}) & w_lane_mask);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state           <= StIdle;
            r_lane            <= 2'b00;
            r_size            <= 2'b00;
            r_unsigned        <= 1'b0;
            r_wdata           <= '0;
            r_wbuf            <= '0;
            r_mem_adr         <= '0;
            r_resp_rdata      <= '0;
            r_resp_valid      <= 1'b0;
            r_resp_misaligned <= 1'b0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
        end else begin
            r_resp_valid      <= 1'b0;
            r_resp_misaligned <= 1'b0;
            r_mem_read        <= 1'b0;
            r_mem_write       <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_lane       <= w_acc_addr[1:0];
                        r_size       <= i_req_size;
                        r_unsigned   <= i_req_unsigned;
                        r_wdata      <= i_req_wdata;
                        r_mem_adr    <= w_word_adr;
                        r_resp_rdata <= '0;
                        if (w_misaligned) begin
                            r_state           <= StResp;
                            r_resp_valid      <= 1'b1;
                            r_resp_misaligned <= 1'b1;
                        end else if (!i_req_write) begin
                            r_state    <= StLoad;
                            r_mem_read <= 1'b1;
                        end else if (i_req_size[1]) begin
                            r_state     <= StWrite;
                            r_mem_write <= 1'b1;
                        end else begin
                            r_state    <= StRmwRd;
                            r_mem_read <= 1'b1;
                        end
                    end
                end
                StLoad: begin
                    r_resp_rdata <= w_load_data;
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                end
                StRmwRd: begin
                    r_wbuf      <= w_merged;
                    r_state     <= StRmwWr;
                    r_mem_write <= 1'b1;
                end
                StWrite, StRmwWr: begin
                    r_state      <= StResp;
                    r_resp_valid <= 1'b1;
                end
                StResp:  r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_req_ready       = (r_state == StIdle);
    assign o_stall           = (i_req_valid & ~o_req_ready) | (r_state != StIdle);
    assign o_resp_valid      = r_resp_valid;
    assign o_resp_rdata      = r_resp_rdata;
    assign o_resp_misaligned = r_resp_misaligned;
    assign o_mem_adr         = r_mem_adr;
    assign o_mem_wdata       = (r_state == StRmwWr) ? r_wbuf : r_wdata;
    // Reset is synchronous, so strobes must be masked during the reset cycle itself.
    assign o_mem_read        = r_mem_read & ~i_rst;
    assign o_mem_write       = r_mem_write & ~i_rst;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: spec vectors, corner sequences and a random run
// against a byte-array reference model.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        stall;
    logic [31:0] mem_adr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    lsu_ctrl #(.ADDR_W(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_size(req_size), .i_req_unsigned(req_unsigned),
        .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_resp_valid(resp_valid),
        .o_resp_rdata(resp_rdata), .o_resp_misaligned(resp_misaligned), .o_stall(stall),
        .o_mem_adr(mem_adr), .o_mem_wdata(mem_wdata), .o_mem_read(mem_read),
        .o_mem_write(mem_write), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] tb_mem [0:255];
    logic [7:0]  ref_bytes [0:1023];
    assign mem_rdata = tb_mem[mem_adr[7:0]];
    always @(posedge clk) if (mem_write) tb_mem[mem_adr[7:0]] <= mem_wdata;

    int checks = 0;
    int failures = 0;
    int rd_cnt = 0, wr_cnt = 0, resp_cnt = 0, proto_err = 0;
    logic [31:0] last_wr_adr = '0, last_wr_data = '0, prev_adr = '0;
    logic        prev_idle = 1'b1;

    always @(negedge clk) begin
        if (!rst) begin
            if (mem_read) rd_cnt++;
            if (mem_write) begin
                wr_cnt++;
                last_wr_adr  = mem_adr;
                last_wr_data = mem_wdata;
            end
            if (resp_valid) resp_cnt++;
            if (mem_read && mem_write) proto_err++;
            if (mem_adr[31:8] != 24'h0) proto_err++;
            if (!prev_idle && !req_ready && mem_adr != prev_adr) proto_err++;
            prev_idle = req_ready;
            prev_adr  = mem_adr;
        end else begin
            prev_idle = 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int n, input logic u);
        logic [31:0] v = '0;
        for (int b = 0; b < n; b++) v = v | (32'(ref_bytes[a[9:0] + 10'(b)]) << (8 * b));
        if (!u && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return v;
    endfunction

    // Reference: computes expected outcome of one access and applies stores to ref_bytes.
    task automatic model_access(input logic w, input logic [1:0] sz, input logic u,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic [31:0] e_rd, output logic e_mis,
                                output int e_lat, output int e_nr, output int e_nw);
        logic [31:0] a = addr;
        int n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e_mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) e_mis = 1'b1;
`else
        a = a & ~32'(n - 1);
`endif
        e_lat = e_mis ? 1 : (!w || n == 4) ? 2 : 3;
        e_rd  = (w || e_mis) ? 32'h0 : ref_load(a, n, u);
        e_nr  = (!e_mis && (!w || n < 4)) ? 1 : 0;
        e_nw  = (!e_mis && w) ? 1 : 0;
        if (w && !e_mis)
            for (int b = 0; b < n; b++) ref_bytes[a[9:0] + 10'(b)] = wd[8*b +: 8];
    endtask

    // Issues one request from an idle-ish point (#1 after a posedge); returns in the RESP cycle.
    task automatic do_req(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output logic mis, output int lat);
        int guard = 0;
        bit got = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u;
        req_addr = addr; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        rd_cnt = 0; wr_cnt = 0;
        lat = 0; rd = '0; mis = 1'b0;
        for (int cyc = 1; cyc <= 10 && !got; cyc++) begin
            if (resp_valid) begin
                got = 1; lat = cyc; rd = resp_rdata; mis = resp_misaligned;
            end else begin
                @(posedge clk); #1;
            end
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL resp_timeout: actual=none required=resp_valid within 10 cycles");
        end
    endtask

    task automatic run_check(input string name, input logic w, input logic [1:0] sz,
                             input logic u, input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] e_rd, input logic e_mis, input int e_lat,
                             input int e_nr, input int e_nw);
        logic [31:0] rd;
        logic mis;
        int lat;
        do_req(w, sz, u, addr, wd, rd, mis, lat);
        check({name, "_rdata"}, rd, e_rd);
        check({name, "_misaligned"}, 32'(mis), 32'(e_mis));
        check({name, "_latency"}, lat, e_lat);
        check({name, "_reads"}, rd_cnt, e_nr);
        check({name, "_writes"}, wr_cnt, e_nw);
    endtask

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        logic [31:0] exp_wdata;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t tbl [15];

    initial begin
        logic [31:0] e_rd, rd;
        logic        e_mis, mis;
        int          e_lat, e_nr, e_nw, lat, resp0, nxt, idx, nresp, bad;
        logic [31:0] bb_addr [3];
        logic [31:0] bb_wd [3];
        logic        bb_w [3];
        logic [1:0]  bb_sz [3];
        logic [31:0] bb_exp [3];

        tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        2, 32'hDEADBEEF, 32'h4};
        tbl[1]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 32'h0,        2, 32'h80FF7F01, 32'h4};
        tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h10, 32'h0,        32'h00000001, 2, 32'h0,        32'h0};
        tbl[4]  = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 2, 32'h0,        32'h0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h00000080, 2, 32'h0,        32'h0};
        tbl[6]  = '{1'b0, 2'd1, 1'b0, 32'h12, 32'h0,        32'hFFFF80FF, 2, 32'h0,        32'h0};
        tbl[7]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h000080FF, 2, 32'h0,        32'h0};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 32'h0,        2, 32'h11223344, 32'h4};
        tbl[9]  = '{1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 32'h0,        3, 32'h1122AA44, 32'h4};
        tbl[10] = '{1'b1, 2'd1, 1'b0, 32'h12, 32'h1234BEEF, 32'h0,        3, 32'hBEEFAA44, 32'h4};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'hBEEFAA44, 2, 32'h0,        32'h0};
        tbl[12] = '{1'b1, 2'd3, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        2, 32'hCAFEF00D, 32'h8};
        tbl[13] = '{1'b0, 2'd3, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 2, 32'h0,        32'h0};
        tbl[14] = '{1'b0, 2'd0, 1'b0, 32'h22, 32'h0,        32'hFFFFFFFE, 2, 32'h0,        32'h0};

        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = $urandom;
            for (int b = 0; b < 4; b++) ref_bytes[4*i+b] = tb_mem[i][8*b +: 8];
        end

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_misaligned", 32'(resp_misaligned), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("rst_mem_adr", mem_adr, 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);

        for (int i = 0; i < 15; i++) begin
            model_access(tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr, tbl[i].wdata,
                         e_rd, e_mis, e_lat, e_nr, e_nw);
            run_check($sformatf("vec%0d", i), tbl[i].w, tbl[i].sz, tbl[i].u, tbl[i].addr,
                      tbl[i].wdata, tbl[i].exp_rdata, 1'b0, tbl[i].exp_lat,
                      (!tbl[i].w || tbl[i].sz < 2) ? 1 : 0, tbl[i].w ? 1 : 0);
            if (tbl[i].w) begin
                check($sformatf("vec%0d_wr_adr", i), last_wr_adr, tbl[i].exp_adr);
                check($sformatf("vec%0d_wr_data", i), last_wr_data, tbl[i].exp_wdata);
            end
        end

        // Reset while the sub-word store is in its write cycle.
        model_access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, e_rd, e_mis, e_lat, e_nr, e_nw);
        do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, rd, mis, lat);
        @(posedge clk); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_addr = 32'h11;
        req_wdata = 32'hAA;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rmw_wr_before_rst", 32'(mem_write), 32'h1);
        resp0 = resp_cnt;
        rst = 1'b1;
        #1 check("rst_gates_write", 32'(mem_write), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_rmw_ready", 32'(req_ready), 32'h1);
        check("rst_rmw_no_resp", 32'(resp_valid), 32'h0);
        repeat (4) @(posedge clk);
        #1 check("rst_rmw_no_resp_later", resp_cnt, resp0);
        check("rst_rmw_mem_kept", tb_mem[4], 32'h11223344);

`ifdef LSU_MISALIGN_CHECK_EN
        run_check("mis_half", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 1, 0, 0);
`else
        run_check("mis_half", 1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 32'h00003344, 1'b0, 2, 1, 0);
`endif
        model_access(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, e_rd, e_mis, e_lat, e_nr, e_nw);

        // Back-to-back: req_valid held high across three requests.
        bb_w[0] = 1'b0; bb_sz[0] = 2'd2; bb_addr[0] = 32'h40; bb_wd[0] = 32'h0;
        bb_w[1] = 1'b1; bb_sz[1] = 2'd0; bb_addr[1] = 32'h41; bb_wd[1] = 32'h5A;
        bb_w[2] = 1'b1; bb_sz[2] = 2'd2; bb_addr[2] = 32'h80; bb_wd[2] = 32'h0BADF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        idx = 0; nxt = 0; nresp = 0;
        for (int t = 0; t < 14; t++) begin
            if (idx < 3) begin
                req_valid = 1'b1; req_write = bb_w[idx]; req_size = bb_sz[idx];
                req_unsigned = 1'b0; req_addr = bb_addr[idx]; req_wdata = bb_wd[idx];
            end else begin
                req_valid = 1'b0;
            end
            #1;
            check($sformatf("bb_ready_t%0d", t), 32'(req_ready), 32'(t >= nxt));
            check($sformatf("bb_stall_t%0d", t), 32'(stall), 32'(t < nxt));
            if (resp_valid) begin
                if (nresp < 3) check($sformatf("bb_rdata%0d", nresp), resp_rdata, bb_exp[nresp]);
                nresp++;
            end
            if (t >= nxt && idx < 3) begin
                model_access(bb_w[idx], bb_sz[idx], 1'b0, bb_addr[idx], bb_wd[idx],
                             bb_exp[idx], e_mis, e_lat, e_nr, e_nw);
                nxt = t + e_lat + 1;
                idx++;
            end
            @(posedge clk); #1;
        end
        check("bb_resp_count", nresp, 3);

        for (int i = 0; i < 200; i++) begin
            logic        w = 1'($urandom);
            logic [1:0]  sz = 2'($urandom);
            logic        u = 1'($urandom);
            logic [31:0] a = $urandom_range(0, 1023);
            logic [31:0] d = $urandom;
            model_access(w, sz, u, a, d, e_rd, e_mis, e_lat, e_nr, e_nw);
            run_check($sformatf("rnd%0d", i), w, sz, u, a, d, e_rd, e_mis, e_lat, e_nr, e_nw);
        end

        @(posedge clk); #1;
        bad = 0;
        for (int i = 0; i < 256; i++)
            if (tb_mem[i] !== {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1],
                               ref_bytes[4*i]}) bad++;
        check("final_mem_mismatches", bad, 0);
        check("protocol_errors", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller for the MEM stage of the pipeline. It accepts byte-addressed load/store requests (byte, halfword, word; signed/unsigned loads) and drives the word-addressed data memory port (`adr`, `writeData`, `memread`, `memwrite`, `readData`). Sub-word stores are done as read-modify-write. The pipeline is stalled until the response is returned.

## Interface
- `ADDR_W`, default 32: request byte-address width.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept; high only in IDLE.
- `req_write` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `req_unsigned` in 1: zero-extend loads; otherwise sign-extend.
- `req_addr` in ADDR_W: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_misaligned` out 1: qualifies `resp_valid`; access was dropped.
- `stall` out 1: `req_valid & ~req_ready` | (state ≠ IDLE).
- `mem_adr` out 32: word address, `{2'b00, addr[ADDR_W-1:2]}` zero-extended.
- `mem_wdata` out 32: word to write.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe; memory writes on the rising edge.
- `mem_rdata` in 32: memory read data; valid by the end of a cycle with `mem_read` high.

## Operation
- **Byte lanes:** little-endian. Byte k of a word is at `[8k+7:8k]`, with k = `addr[1:0]`. Halfword h is at `[16h+15:16h]`, with h = `addr[1]`.
- **Acceptance:** on `req_valid & req_ready`, latch addr, size, write, unsigned and wdata into registers. All later states use only the latched copy.
- **State machine states:**
  - **IDLE:** `req_ready` = 1. On accept, select the next state:
    - misaligned → RESP with the error flag set;
    - load → LOAD;
    - word store → WRITE;
    - byte/half store → RMW_RD.
  - **LOAD:** `mem_read` = 1. At the edge, extract the lane from `mem_rdata`, extend it, and register it into `resp_rdata`. Next state RESP.
  - **RMW_RD:** `mem_read` = 1. At the edge, merge `mem_rdata` with the store lane(s) into `wbuf`; the other lanes are preserved bit-exact. Next state RMW_WR.
  - **WRITE / RMW_WR:** `mem_write` = 1. `mem_wdata` = latched wdata (WRITE) or `wbuf` (RMW_WR). Next state RESP.
  - **RESP:** `resp_valid` = 1 for exactly one cycle. Next state IDLE. A new request is not accepted in RESP.
- **Memory port discipline:**
  - `mem_adr` is held stable for every cycle outside IDLE.
  - `mem_read` and `mem_write` are never high together.
  - Both strobes are gated by `~rst`.
- **Reset:** `rst` mid-operation drops the in-flight request. No memory write is issued in the cycle `rst` is high, and no `resp_valid` pulse follows.

## Timing
- **Reset values:**
  - state = IDLE, `req_ready` = 1;
  - `resp_valid` = 0, `resp_misaligned` = 0;
  - `resp_rdata` = 0, `wbuf` = 0;
  - `mem_read` = 0, `mem_write` = 0;
  - `mem_adr` = 0, `mem_wdata` = 0.
- **Latency** (accept at cycle 0, cycle N = `resp_valid` high):
  - load: 2;
  - word store: 2;
  - sub-word store: 3;
  - misaligned error: 1.
- **Throughput:** one request per latency+1 cycles. `req_ready` returns high the cycle after RESP.
- **Visibility:** a store's memory update is visible to a load accepted in the cycle after RESP.

## Configuration
- **`LSU_MISALIGN_CHECK_EN` defined:**
  - half with `addr[0]` = 1, or word with `addr[1:0]` ≠ 0, is misaligned;
  - no memory access is made;
  - RESP pulses with `resp_misaligned` = 1 and `resp_rdata` = 0.
- **`LSU_MISALIGN_CHECK_EN` undefined:**
  - low address bits are forced to zero: `addr[0]` for half, `addr[1:0]` for word;
  - the access proceeds normally;
  - `resp_misaligned` is tied to 0.

## Test plan
- **Word store then load:** word store of 0xDEADBEEF to addr 0x10 → one `mem_write` cycle with `mem_adr` = 4 and `resp_valid` at cycle 2. Then word load from 0x10 → `resp_rdata` = 0xDEADBEEF at cycle 2.
- **Signed/unsigned byte loads:** word 0x80FF7F01 at word 4. Byte loads give:
  - 0x10 signed → 0x00000001;
  - 0x13 signed → 0xFFFFFF80;
  - 0x13 unsigned → 0x00000080;
  - half load from 0x12 signed → 0xFFFF80FF.
- **Sub-word store read-modify-write:** word 4 = 0x11223344, then store byte 0xAA to 0x11 → `mem_read` cycle 1, `mem_write` cycle 2 with `mem_wdata` = 0x1122AA44, `resp_valid` at cycle 3.
- **Misaligned half load** to 0x11 (macro defined) → `resp_valid` and `resp_misaligned` at cycle 1, no strobe issued. With the macro undefined → aligned half read from 0x10.
- **Reset during RMW:** assert `rst` while in RMW_WR → `mem_write` stays 0, memory word unchanged, no `resp_valid`, `req_ready` = 1 on the next cycle.
- **Back-to-back requests:** `req_valid` held high for 3 requests → each is accepted only when `req_ready` = 1, `stall` is high exactly during the busy cycles, and no request is lost or duplicated.
